bk_slot_engine: RTL and testbench
=================================

// Module: bk_slot_engine
// PURPOSE
//  Parametrised save-state transfer engine between the core's backup RAM and the HPS SD block interface.
//  Streams one contiguous run of 512-byte sectors per request: load (HPS->core) or save (core->HPS).
//  Supports 2**SLOT_BITS slots, a runtime sector count, a base LBA, ack timeout and error reporting.
//  Sits in the emu top between status/OSD bits and hps_io sd_* ports; drives add_bk/core-hold.
// PARAMETERS
//  SLOT_BITS    2        slot select width; slot stride = 2**SECT_BITS sectors
//  SECT_BITS    6        sector index width; max 2**SECT_BITS sectors per slot
//  LBA_W        32       sd_lba width
//  TIMEOUT_W    24       ack-timeout counter width; 0 in timeout_lim disables timeout
// PORTS
//  clk_sys      in   1            system clock
//  reset        in   1            asynchronous, active-high reset
//  ena          in   1            save file mounted and writable-capable (gates all requests)
//  img_readonly in   1            mounted image read-only; save requests rejected
//  load_req     in   1            level; rising edge starts load
//  save_req     in   1            level; rising edge starts save
//  slot         in   SLOT_BITS    slot number, sampled at start
//  num_sect     in   SECT_BITS+1  sectors to transfer, 1..2**SECT_BITS, sampled at start
//  base_lba     in   LBA_W        LBA of slot 0 sector 0, sampled at start
//  timeout_lim  in   TIMEOUT_W    cycles allowed from request to ack rise
//  sd_ack       in   1            hps_io sector acknowledge
//  sd_lba       out  LBA_W        sector address to hps_io
//  sd_rd        out  1            sector read request
//  sd_wr        out  1            sector write request
//  sect_idx     out  SECT_BITS    current sector within slot (forms add_bk high bits)
//  busy         out  1            transfer in progress (drives LED)
//  loading      out  1            load in progress; OR'd into core reset
//  done         out  1            1-cycle pulse on successful completion
//  error        out  1            sticky; set on timeout or rejected save, cleared at next accepted start
// BEHAVIOUR
//  - Reset: sd_lba=0, sd_rd=0, sd_wr=0, sect_idx=0, busy=0, loading=0, done=0, error=0, state IDLE,
//    edge detectors loaded with 1 so a request held high through reset does not fire.
//  - Edge detect: req_rise = req & ~req_q, req_q registered every cycle, gated by ena.
//  - Both rises same cycle: load wins, save ignored. Rises while not IDLE ignored.
//  - save rise with img_readonly=1 or num_sect=0 or num_sect>2**SECT_BITS: error<=1, stay IDLE.
//  - States: IDLE -> REQ -> XFER -> (REQ | FIN) -> IDLE; ERR path REQ -> IDLE.
//  - IDLE accept (cycle N): sd_lba <= base_lba + {slot, SECT_BITS'0}; sect_idx<=0; busy<=1;
//    loading<=is_load; error<=0; sd_rd<=is_load, sd_wr<=~is_load at N+1; enter REQ.
//  - REQ: on ack rise (ack & ~ack_q) drop sd_rd/sd_wr next cycle, go XFER. Counter increments each
//    REQ cycle; reaching timeout_lim (nonzero) -> drop rd/wr, error<=1, busy<=0, loading<=0, IDLE.
//  - XFER: on ack fall: if sect_idx==num_sect-1 -> FIN; else sect_idx+1, sd_lba+1, reassert
//    rd/wr next cycle, counter cleared, REQ. LBA add wraps modulo 2**LBA_W.
//  - FIN: busy<=0, loading<=0, done<=1 for exactly one cycle, IDLE.
//  - ena falling mid-transfer: finish current sector handshake, then abort to IDLE with error<=1.
//  - Async reset mid-transfer: immediate return to reset values; HPS side tolerates dropped req.
//  - sd_rd and sd_wr never both 1; never asserted outside REQ.
// STRUCTURE
//  - Package bk_pkg: state enum (IDLE, REQ, XFER, FIN), SECTOR_BYTES=512, shared with save-RAM mux.
//  - Sub-module edge_det (1-bit registered rising/falling edge, async reset) used for load, save, ack.
//  - Single always_ff FSM + datapath; no memories inside the block.
// TESTING
//  - Load slot 2, num_sect=64, base_lba=0: sd_lba 128..191 in order, 64 rd pulses, 0 wr, done once, loading high throughout.
//  - Save slot 1, num_sect=3, base_lba=1000: sd_lba 1064,1065,1066, sd_wr only, done after 3rd ack fall.
//  - load_req and save_req rise same cycle: load executes, no sd_wr ever asserted.
//  - Save with img_readonly=1: error=1 next cycle, busy stays 0, no sd_wr; later valid load clears error.
//  - timeout_lim=100, ack never rises: sd_rd drops and error=1 at cycle 100 after request, busy=0.
//  - Assert reset during sector 5 of a load: all outputs 0 immediately; load_req held high after release causes no restart.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared constants for the backup-RAM slot engine and the save-RAM mux.
package bk_pkg;

  localparam int unsigned SECTOR_BYTES = 512;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
  localparam logic [ST_W-1:0] ST_XFER = 2'd2;
  localparam logic [ST_W-1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/edge_det.sv
// One-bit registered edge detector; INIT sets the history bit value held in reset.
module edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic hist_q, hist_d;

  always_comb begin
    hist_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= INIT;
    else     hist_q <= hist_d;
  end

  assign rise_c = d & ~hist_q;
  assign fall_c = ~d & hist_q;

endmodule

// File: rtl/bk_slot_engine.sv
// Streams a contiguous run of 512-byte sectors between backup RAM and the HPS SD
// interface, one request per load/save rising edge.
module bk_slot_engine
  import bk_pkg::*;
#(
  parameter int unsigned SLOT_BITS = 2,
  parameter int unsigned SECT_BITS = 6,
  parameter int unsigned LBA_W     = 32,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 img_readonly,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic [SECT_BITS:0]   num_sect,
  input  logic [LBA_W-1:0]     base_lba,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  input  logic                 sd_ack,
  output logic [LBA_W-1:0]     sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic [SECT_BITS-1:0] sect_idx,
  output logic                 busy,
  output logic                 loading,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned NUM_W = SECT_BITS + 1;
  localparam logic [SECT_BITS:0] MAX_SECT = {1'b1, {SECT_BITS{1'b0}}};

  logic [ST_W-1:0]      state_q, state_d;
  logic [LBA_W-1:0]     sd_lba_q, sd_lba_d;
  logic                 sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [SECT_BITS-1:0] sect_idx_q, sect_idx_d;
  logic                 busy_q, busy_d, loading_q, loading_d;
  logic                 done_q, done_d, error_q, error_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [SECT_BITS:0]   num_q, num_d;
  logic                 ena_lost_q, ena_lost_d;

  logic load_rise, save_rise, ack_rise, ack_fall;
  logic load_fall_unused, save_fall_unused;
  logic load_go, save_go, save_ok, timeout_hit;
  logic [TIMEOUT_W-1:0] cnt_nxt;
  logic [NUM_W-1:0]     sect_nxt;

  // Request detectors hold 1 in reset so a level held through reset never fires.
  edge_det #(.INIT(1'b1)) u_load_det (
    .clk(clk_sys), .rst(reset), .d(load_req), .rise_c(load_rise), .fall_c(load_fall_unused)
  );
  edge_det #(.INIT(1'b1)) u_save_det (
    .clk(clk_sys), .rst(reset), .d(save_req), .rise_c(save_rise), .fall_c(save_fall_unused)
  );
  edge_det #(.INIT(1'b0)) u_ack_det (
    .clk(clk_sys), .rst(reset), .d(sd_ack), .rise_c(ack_rise), .fall_c(ack_fall)
  );

  assign load_go     = ena & load_rise;
  assign save_go     = ena & save_rise & ~load_go;
  assign save_ok     = ~img_readonly && (num_sect != '0) && (num_sect <= MAX_SECT);
  assign cnt_nxt     = cnt_q + TIMEOUT_W'(1);
  assign timeout_hit = (timeout_lim != '0) && (cnt_nxt >= timeout_lim);
  assign sect_nxt    = {1'b0, sect_idx_q} + NUM_W'(1);

  always_comb begin
    state_d    = state_q;
    sd_lba_d   = sd_lba_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    sect_idx_d = sect_idx_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    done_d     = 1'b0;
    error_d    = error_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    ena_lost_d = ena_lost_q | (busy_q & ~ena);

    case (state_q)
      ST_IDLE: begin
        ena_lost_d = 1'b0;
        if (load_go || (save_go && save_ok)) begin
          state_d    = ST_REQ;
          sd_lba_d   = base_lba + LBA_W'({slot, {SECT_BITS{1'b0}}});
          sect_idx_d = '0;
          busy_d     = 1'b1;
          loading_d  = load_go;
          error_d    = 1'b0;
          sd_rd_d    = load_go;
          sd_wr_d    = ~load_go;
          cnt_d      = '0;
          num_d      = num_sect;
        end else if (save_go) begin
          error_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_rise) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_nxt;
          if (timeout_hit) begin
            sd_rd_d   = 1'b0;
            sd_wr_d   = 1'b0;
            error_d   = 1'b1;
            busy_d    = 1'b0;
            loading_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_XFER: begin
        // Sector boundary: abort if ena was lost, finish, or request the next sector.
        if (ack_fall) begin
          if (ena_lost_q || !ena) begin
            error_d   = 1'b1;
            busy_d    = 1'b0;
            loading_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (sect_nxt >= num_q) begin
            state_d = ST_FIN;
          end else begin
            sect_idx_d = sect_nxt[SECT_BITS-1:0];
            sd_lba_d   = sd_lba_q + LBA_W'(1);
            sd_rd_d    = loading_q;
            sd_wr_d    = ~loading_q;
            cnt_d      = '0;
            state_d    = ST_REQ;
          end
        end
      end
      ST_FIN: begin
        busy_d    = 1'b0;
        loading_d = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sd_lba_q   <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      sect_idx_q <= '0;
      busy_q     <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      num_q      <= '0;
      ena_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      sect_idx_q <= sect_idx_d;
      busy_q     <= busy_d;
      loading_q  <= loading_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      ena_lost_q <= ena_lost_d;
    end
  end

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign sect_idx = sect_idx_q;
  assign busy     = busy_q;
  assign loading  = loading_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_bk_slot_engine.sv
// Directed bench for bk_slot_engine: HPS ack handshake driven inline, pulse counts kept by a monitor.
module tb_bk_slot_engine;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ena;
  logic        img_readonly;
  logic        load_req;
  logic        save_req;
  logic [1:0]  slot;
  logic [6:0]  num_sect;
  logic [31:0] base_lba;
  logic [23:0] timeout_lim;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [5:0]  sect_idx;
  logic        busy;
  logic        loading;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0, wr_pulses = 0, done_pulses = 0, both_hi = 0;
  logic rd_prev = 1'b0, wr_prev = 1'b0;
  int rd0, wr0, dn0;

  bk_slot_engine dut (
    .clk_sys(clk_sys), .reset(reset), .ena(ena), .img_readonly(img_readonly),
    .load_req(load_req), .save_req(save_req), .slot(slot), .num_sect(num_sect),
    .base_lba(base_lba), .timeout_lim(timeout_lim), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sect_idx(sect_idx),
    .busy(busy), .loading(loading), .done(done), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (sd_rd && !rd_prev) rd_pulses++;
    if (sd_wr && !wr_prev) wr_pulses++;
    if (done) done_pulses++;
    if (sd_rd && sd_wr) both_hi++;
    rd_prev = sd_rd;
    wr_prev = sd_wr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_lba"},  sd_lba, 0);
    check({tag, "_rd"},   32'(sd_rd), 0);
    check({tag, "_wr"},   32'(sd_wr), 0);
    check({tag, "_idx"},  32'(sect_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_load"}, 32'(loading), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"},  32'(error), 0);
  endtask

  // Drops both requests for a cycle, then raises the chosen ones with new parameters.
  task automatic start(input logic ld, input logic sv, input int s, input int n, input logic [31:0] base);
    load_req = 1'b0;
    save_req = 1'b0;
    tick();
    slot     = 2'(s);
    num_sect = 7'(n);
    base_lba = base;
    load_req = ld;
    save_req = sv;
    rd0 = rd_pulses; wr0 = wr_pulses; dn0 = done_pulses;
  endtask

  // One HPS sector handshake; returns with ack just dropped.
  task automatic serve_one(input logic [31:0] lba, input int rd_exp, input int idx);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(sd_rd || sd_wr) && n < 50);
    check("req_seen", 32'(sd_rd | sd_wr), 1);
    check("lba", sd_lba, lba);
    check("rd", 32'(sd_rd), 32'(rd_exp));
    check("wr", 32'(sd_wr), 32'(1 - rd_exp));
    check("idx", 32'(sect_idx), 32'(idx));
    check("loading", 32'(loading), 32'(rd_exp));
    sd_ack = 1'b1;
    tick();
    check("req_drop", 32'(sd_rd | sd_wr), 0);
    tick();
    sd_ack = 1'b0;
  endtask

  task automatic finish_xfer();
    tick();
    check("fin_busy", 32'(busy), 1);
    check("fin_nodone", 32'(done), 0);
    tick();
    check("done_hi", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_loading", 32'(loading), 0);
    tick();
    check("done_lo", 32'(done), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ena = 1'b1; img_readonly = 1'b0; load_req = 1'b0; save_req = 1'b0;
    slot = '0; num_sect = '0; base_lba = '0; timeout_lim = '0; sd_ack = 1'b0;
    tick(); tick();
    check_quiet("rst");
    reset = 1'b0;
    tick();

    // Load slot 2, all 64 sectors.
    start(1'b1, 1'b0, 2, 64, 32'd0);
    for (int i = 0; i < 64; i++) serve_one(32'(128 + i), 1, i);
    finish_xfer();
    check("ld64_rd_pulses", 32'(rd_pulses - rd0), 64);
    check("ld64_wr_pulses", 32'(wr_pulses - wr0), 0);
    check("ld64_done_cnt", 32'(done_pulses - dn0), 1);

    // Save slot 1, 3 sectors at base 1000.
    start(1'b0, 1'b1, 1, 3, 32'd1000);
    for (int i = 0; i < 3; i++) serve_one(32'(1064 + i), 0, i);
    finish_xfer();
    check("sv3_rd_pulses", 32'(rd_pulses - rd0), 0);
    check("sv3_wr_pulses", 32'(wr_pulses - wr0), 3);

    // Simultaneous rises: load wins.
    start(1'b1, 1'b1, 0, 1, 32'd5);
    serve_one(32'd5, 1, 0);
    finish_xfer();
    check("both_wr_pulses", 32'(wr_pulses - wr0), 0);
    check("both_rd_pulses", 32'(rd_pulses - rd0), 1);

    // Read-only save is rejected; a later load clears the error.
    img_readonly = 1'b1;
    start(1'b0, 1'b1, 1, 2, 32'd0);
    tick();
    check("ro_err", 32'(error), 1);
    check("ro_busy", 32'(busy), 0);
    repeat (3) tick();
    check("ro_busy_late", 32'(busy), 0);
    check("ro_wr_pulses", 32'(wr_pulses - wr0), 0);
    img_readonly = 1'b0;
    start(1'b1, 1'b0, 3, 1, 32'd0);
    tick();
    check("clr_err", 32'(error), 0);
    check("clr_busy", 32'(busy), 1);
    serve_one(32'd192, 1, 0);
    finish_xfer();

    // Out-of-range sector counts on save.
    start(1'b0, 1'b1, 0, 0, 32'd0);
    tick();
    check("n0_err", 32'(error), 1);
    check("n0_busy", 32'(busy), 0);
    start(1'b0, 1'b1, 0, 65, 32'd0);
    repeat (2) tick();
    check("n65_busy", 32'(busy), 0);
    check("n65_wr_pulses", 32'(wr_pulses - wr0), 0);

    // LBA wraps modulo 2**32.
    start(1'b1, 1'b0, 0, 2, 32'hFFFF_FFFF);
    serve_one(32'hFFFF_FFFF, 1, 0);
    serve_one(32'h0000_0000, 1, 1);
    finish_xfer();

    // Ack never rises: request dropped on the 100th cycle.
    timeout_lim = 24'd100;
    start(1'b1, 1'b0, 0, 1, 32'd0);
    tick();
    check("to_rd_start", 32'(sd_rd), 1);
    repeat (99) tick();
    check("to_rd_99", 32'(sd_rd), 1);
    check("to_err_99", 32'(error), 0);
    tick();
    check("to_rd_100", 32'(sd_rd), 0);
    check("to_err_100", 32'(error), 1);
    check("to_busy_100", 32'(busy), 0);
    timeout_lim = '0;

    // ena lost mid-transfer: current sector completes, then abort.
    start(1'b1, 1'b0, 0, 4, 32'h10);
    serve_one(32'h10, 1, 0);
    tick();
    check("ena_rd_s1", 32'(sd_rd), 1);
    ena = 1'b0;
    sd_ack = 1'b1;
    tick();
    tick();
    sd_ack = 1'b0;
    tick();
    check("ena_busy", 32'(busy), 0);
    check("ena_err", 32'(error), 1);
    ena = 1'b1;
    repeat (4) tick();
    check("ena_rd_after", 32'(rd_pulses - rd0), 2);

    // Reset during sector 5 of a load, request held high across release.
    start(1'b1, 1'b0, 0, 8, 32'd0);
    for (int i = 0; i < 5; i++) serve_one(32'(i), 1, i);
    tick();
    check("rst_s5_idx", 32'(sect_idx), 5);
    reset = 1'b1;
    #1;
    check_quiet("midrst");
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_norestart_busy", 32'(busy), 0);
    check("rst_norestart_rd", 32'(sd_rd), 0);
    load_req = 1'b0;
    tick();

    check("rd_wr_exclusive", 32'(both_hi), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
